// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED fader output stage.
package led_pkg;

    // Default brightness resolution in bits.
    localparam int unsigned PwmBitsDefault = 8;

    // Ramp direction chosen for the current cycle.
    typedef enum logic [1:0] {
        RampHold,
        RampUp,
        RampDown
    } ramp_e;

    // Clock cycles per brightness step. Returns 0 for an unusable step rate.
    function automatic int unsigned calc_div(input int unsigned clk_freq_hz,
                                             input int unsigned step_hz);
        return (step_hz == 0) ? 0 : clk_freq_hz / step_hz;
    endfunction

    // Largest brightness level for a given resolution.
    function automatic int unsigned level_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM renderer: free-running counter over 2^N-1 cycles with a registered compare.
module led_pwm
    import led_pkg::*;
#(
    parameter int unsigned pwm_bits = PwmBitsDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [pwm_bits-1:0] level,
    output logic                o
);

    // Last counter value; the period is 2^N-1 so full scale gives a constant high.
    localparam logic [pwm_bits-1:0] PLast = pwm_bits'(level_max(pwm_bits) - 1);

    logic [pwm_bits-1:0] p_q, p_d;
    logic                o_q, o_d;

    // Next counter value and compare result.
    always_comb begin
        p_d = (p_q == PLast) ? '0 : p_q + pwm_bits'(1);
        o_d = (p_q < level);
    end

    // Counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            o_q <= 1'b0;
        end else begin
            p_q <= p_d;
            o_q <= o_d;
        end
    end

    assign o = o_q;

endmodule

// File: rtl/led_fader.sv
// Breathing LED stage: synchronises the blinky output, ramps brightness toward it at a
// fixed step rate and renders the brightness through led_pwm.
module led_fader
    import led_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 125_000_000,
    parameter int unsigned step_hz     = 1_000,
    parameter int unsigned pwm_bits    = PwmBitsDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i,
    input  logic                en,
    output logic                o,
    output logic [pwm_bits-1:0] level,
    output logic                busy
);

    localparam int unsigned Div  = calc_div(clk_freq_hz, step_hz);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0]     CntLast  = CntW'(Div - 1);
    localparam logic [pwm_bits-1:0] LevelMax = pwm_bits'(level_max(pwm_bits));

    if (Div < 1) begin : g_div_check
        $error("led_fader: clk_freq_hz/step_hz must be at least 1");
    end

    logic [1:0]          sync_q, sync_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [pwm_bits-1:0] level_q, level_d;
    logic                i_s;
    logic                tick;
    logic [pwm_bits-1:0] target;
    ramp_e               ramp;

    assign i_s    = sync_q[1];
    assign tick   = (cnt_q == CntLast);
    assign target = i_s ? LevelMax : '0;

    // Synchroniser shift, prescaler advance and saturating level ramp.
    always_comb begin
        sync_d = {sync_q[0], i};

        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end

        ramp = RampHold;
        if (en && tick) begin
            if (i_s && (level_q != LevelMax)) begin
                ramp = RampUp;
            end else if (!i_s && (level_q != '0)) begin
                ramp = RampDown;
            end
        end

        level_d = level_q;
        unique case (ramp)
            RampUp:   level_d = level_q + pwm_bits'(1);
            RampDown: level_d = level_q - pwm_bits'(1);
            RampHold: level_d = level_q;
            default:  level_d = level_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign busy  = (level_q != target);

    led_pwm #(
        .pwm_bits(pwm_bits)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .level(level_q),
        .o    (o)
    );

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with DIV=10 and 4-bit brightness (max 15, period 15).
module tb_led_fader;

    localparam int unsigned ClkHz  = 1000;
    localparam int unsigned StepHz = 100;
    localparam int unsigned Bits   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i   = 1'b1;
    logic            en  = 1'b1;
    logic            o;
    logic            busy;
    logic [Bits-1:0] level;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int          ones;

    always #5 clk = ~clk;

    led_fader #(
        .clk_freq_hz(ClkHz),
        .step_hz    (StepHz),
        .pwm_bits   (Bits)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .i    (i),
        .en   (en),
        .o    (o),
        .level(level),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_async_o", o, 0);
        chk("rst_async_level", level, 0);
        chk("rst_async_busy", busy, 0);
        repeat (3) begin
            cyc();
            chk("rst_hold_o", o, 0);
            chk("rst_hold_level", level, 0);
            chk("rst_hold_busy", busy, 0);
        end
        rst = 1'b0;

        // Ramp up with i=1: busy after two sync stages, one step per 10 cycles.
        cyc();
        chk("busy_edge1", busy, 0);
        chk("level_edge1", level, 0);
        cyc();
        chk("busy_edge2", busy, 1);
        chk("level_edge2", level, 0);
        for (int k = 3; k <= 150; k++) begin
            cyc();
            chk("ramp_up", level, k / 10);
        end
        chk("busy_at_max", busy, 0);
        for (int k = 0; k < 30; k++) begin
            cyc();
            chk("o_full", o, 1);
        end

        // Ramp down to zero and saturate.
        i = 1'b0;
        for (int j = 1; j <= 160; j++) begin
            cyc();
            chk("ramp_down", level, (j >= 150) ? 0 : 15 - j / 10);
        end
        chk("busy_at_zero", busy, 0);
        for (int k = 0; k < 30; k++) begin
            cyc();
            chk("o_zero", o, 0);
        end

        // Ramp to 4 then freeze; duty must be 4 of every 15 cycles.
        i = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            cyc();
            chk("ramp_to4", level, j / 10);
        end
        en = 1'b0;
        for (int p = 0; p < 10; p++) begin
            ones = 0;
            for (int c = 0; c < 15; c++) begin
                cyc();
                ones += int'(o);
            end
            chk("pwm_duty4", ones, 4);
        end
        chk("frozen_level", level, 4);
        chk("frozen_busy", busy, 1);

        // Resume to 7, then reverse without a jump.
        en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            cyc();
            chk("ramp_to7", level, 4 + j / 10);
        end
        i = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            cyc();
            chk("reverse", level, 7 - j / 10);
        end

        // Ramp to 9 and reset mid-ramp.
        i = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            cyc();
            chk("ramp_to9", level, 5 + j / 10);
        end
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("mid_level", level, 9);
            chk("mid_busy", busy, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_level", level, 0);
        chk("rst_mid_o", o, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (3) begin
            cyc();
            chk("rst_mid_hold_level", level, 0);
            chk("rst_mid_hold_o", o, 0);
        end
        rst = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            cyc();
            chk("post_rst", level, j / 10);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
